hazard_sched: RTL

Pipeline hazard controller and execute-stage scheduler for the RV32I core. Generates the ForwardAE/ForwardBE selects for the execute-stage operand muxes. Generates stall/flush controls for load-use and taken-branch/jump hazards. Sequences an external multicycle functional unit (MUL/DIV) through a start/done handshake, freezing the front of the pipeline and injecting bubbles into memory until the result is ready.

---
 rtl/hazard_if.sv | 46 ++++
 rtl/hazard_sched.sv | 102 ++++++++++
 2 files changed

// File: rtl/hazard_if.sv
// Hazard/scheduler bundle between the RV32I pipeline (master) and hazard_sched (slave).
interface hazard_if;
    localparam int unsigned REG_W = 5;

    // Pipeline register indices and controls
    logic [REG_W-1:0] Rs1D;
    logic [REG_W-1:0] Rs2D;
    logic [REG_W-1:0] Rs1E;
    logic [REG_W-1:0] Rs2E;
    logic [REG_W-1:0] RdE;
    logic [REG_W-1:0] RdM;
    logic [REG_W-1:0] RdW;
    logic             RegWriteM;
    logic             RegWriteW;
    logic [1:0]       ResultSrcE;
    logic             PCSrcE;
    logic             McReqE;
    logic             McDone;

    // Hazard-unit controls back to the pipeline
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             FlushD;
    logic             FlushE;
    logic             FlushM;
    logic             McStart;
    logic             McBusy;
    logic             McErr;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, McReqE, McDone,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE,
        input  FlushD, FlushE, FlushM, McStart, McBusy, McErr
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, McReqE, McDone,
        output ForwardAE, ForwardBE, StallF, StallD, StallE,
        output FlushD, FlushE, FlushM, McStart, McBusy, McErr
    );
endinterface

// File: rtl/hazard_sched.sv
// Hazard controller: operand forwarding, load-use / branch stall-flush,
// and start/done sequencing of the external multicycle MUL/DIV unit.
module hazard_sched #(
    parameter int unsigned MC_TIMEOUT = 64
) (
    input logic     clk,
    input logic     rst,
    hazard_if.slave hif
);
    localparam int unsigned CNT_W = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic             lw_stall;
    logic             mc_hold;
    logic             br_flush;

    // Execute-operand forwarding; memory stage beats writeback, x0 never forwards
    always_comb begin
        hif.ForwardAE = 2'b00;
        hif.ForwardBE = 2'b00;
        if (hif.RegWriteM && (hif.RdM != '0) && (hif.RdM == hif.Rs1E)) begin
            hif.ForwardAE = 2'b10;
        end else if (hif.RegWriteW && (hif.RdW != '0) && (hif.RdW == hif.Rs1E)) begin
            hif.ForwardAE = 2'b01;
        end
        if (hif.RegWriteM && (hif.RdM != '0) && (hif.RdM == hif.Rs2E)) begin
            hif.ForwardBE = 2'b10;
        end else if (hif.RegWriteW && (hif.RdW != '0) && (hif.RdW == hif.Rs2E)) begin
            hif.ForwardBE = 2'b01;
        end
    end

    // Multicycle sequencer state, timeout counter and sticky error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next state: McDone wins over a coincident timeout; DONE always returns to IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (hif.McReqE) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (hif.McDone) begin
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(MC_TIMEOUT - 1)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stall/flush/start outputs; a held multicycle op masks branch and load-use hazards
    always_comb begin
        lw_stall = (hif.ResultSrcE == 2'b01) && (hif.RdE != '0) &&
                   ((hif.RdE == hif.Rs1D) || (hif.RdE == hif.Rs2D));
        mc_hold  = ((state_q == IDLE) && hif.McReqE) || (state_q == RUN);
        br_flush = hif.PCSrcE;

        hif.McStart = (state_q == IDLE) && hif.McReqE;
        hif.McBusy  = (state_q == RUN);
        hif.McErr   = err_q;
        hif.StallF  = (lw_stall && !br_flush) || mc_hold;
        hif.StallD  = (lw_stall && !br_flush) || mc_hold;
        hif.StallE  = mc_hold;
        hif.FlushD  = br_flush && !mc_hold;
        hif.FlushE  = (lw_stall || br_flush) && !mc_hold;
        hif.FlushM  = mc_hold;
    end
endmodule
